// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit debounce filter with sticky edge flags and a masked level irq.
// Edge flags, masks and irq exist only when GPIO_EDGE_IRQ_EN is defined; otherwise they tie to 0.
module gpio_in_filter #(
    parameter int IOWidth   = 36,
    parameter int FiltWidth = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IOWidth-1:0]   data_from_gpio,
    input  logic [IOWidth-1:0]   filt_ena,
    input  logic [FiltWidth-1:0] filt_period,
    output logic [IOWidth-1:0]   data_filtered,
    output logic [IOWidth-1:0]   rise_flags,
    output logic [IOWidth-1:0]   fall_flags,
    input  logic [IOWidth-1:0]   flag_clear,
    input  logic [IOWidth-1:0]   rise_mask,
    input  logic [IOWidth-1:0]   fall_mask,
    output logic                 irq
);
    localparam logic [FiltWidth-1:0] CntOne = FiltWidth'(1);

    logic [IOWidth-1:0]   sync_q, filt_q, filt_d;
    logic [FiltWidth-1:0] cnt_q [IOWidth];
    logic [FiltWidth-1:0] cnt_d [IOWidth];

    // The counter only advances while below the threshold, so it cannot wrap.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < IOWidth; i++) begin
            cnt_d[i] = '0;
            if (!filt_ena[i]) begin
                filt_d[i] = sync_q[i];
            end else if (sync_q[i] != filt_q[i]) begin
                if (cnt_q[i] >= filt_period) filt_d[i] = sync_q[i];
                else if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            filt_q <= '0;
            for (int i = 0; i < IOWidth; i++) cnt_q[i] <= '0;
        end else begin
            sync_q <= data_from_gpio;
            filt_q <= filt_d;
            for (int i = 0; i < IOWidth; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign data_filtered = filt_q;

`ifdef GPIO_EDGE_IRQ_EN
    logic [IOWidth-1:0] rise_q, rise_d, fall_q, fall_d;
    logic               irq_q, irq_d;

    // A set on the same edge as a clear wins because it is OR-ed in after the clear.
    always_comb begin
        rise_d = (rise_q & ~flag_clear) | (filt_d & ~filt_q);
        fall_d = (fall_q & ~flag_clear) | (~filt_d & filt_q);
        irq_d  = |((rise_q & rise_mask) | (fall_q & fall_mask));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            irq_q  <= irq_d;
        end
    end

    assign rise_flags = rise_q;
    assign fall_flags = fall_q;
    assign irq        = irq_q;
`else
    logic unused_flag_inputs;

    assign unused_flag_inputs = ^{flag_clear, rise_mask, fall_mask};
    assign rise_flags         = '0;
    assign fall_flags         = '0;
    assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed stimulus with a cycle-stamped scoreboard of expected output bits.
module tb_gpio_in_filter;
    localparam int W  = 36;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  data_from_gpio, filt_ena, flag_clear, rise_mask, fall_mask;
    logic [FW-1:0] filt_period;
    logic [W-1:0]  data_filtered, rise_flags, fall_flags;
    logic          irq;

    gpio_in_filter #(.IOWidth(W), .FiltWidth(FW)) dut (
        .clk(clk), .reset_n(reset_n), .data_from_gpio(data_from_gpio), .filt_ena(filt_ena),
        .filt_period(filt_period), .data_filtered(data_filtered), .rise_flags(rise_flags),
        .fall_flags(fall_flags), .flag_clear(flag_clear), .rise_mask(rise_mask),
        .fall_mask(fall_mask), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        int    kind;
        int    b;
        logic  v;
    } exp_t;

    exp_t sb[$];
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;

    function automatic logic fl(input logic v);
`ifdef GPIO_EDGE_IRQ_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push(input int c, input string tag, input int kind, input int b, input logic v);
        sb.push_back('{c, tag, kind, b, v});
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic obs_of(input int kind, input int b);
        case (kind)
            0:       return data_filtered[b];
            1:       return rise_flags[b];
            2:       return fall_flags[b];
            default: return irq;
        endcase
    endfunction

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Kinds: 0 data_filtered, 1 rise_flags, 2 fall_flags, 3 irq; checked 1 time unit after each edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, W'(obs_of(sb[i].kind, sb[i].b)), W'(sb[i].v));
                sb.delete(i);
            end
        end
    end

    initial begin
        int c;
        reset_n        = 1'b0;
        data_from_gpio = '0;
        filt_ena       = W'(1);
        filt_period    = 8'd5;
        flag_clear     = '0;
        rise_mask      = W'(1);
        fall_mask      = '0;
        negs(2);
        chk("rst_filt", data_filtered, '0);
        chk("rst_rise", rise_flags, '0);
        chk("rst_fall", fall_flags, '0);
        chk("rst_irq", W'(irq), '0);
        reset_n = 1'b1;
        negs(2);

        c = cyc;
        data_from_gpio[0] = 1'b1;
        push(c + 6, "lat_early", 0, 0, 1'b0);
        push(c + 7, "lat_exact", 0, 0, 1'b1);
        push(c + 6, "rise_early", 1, 0, 1'b0);
        push(c + 7, "rise_set", 1, 0, fl(1'b1));
        push(c + 7, "irq_lag", 3, 0, 1'b0);
        push(c + 8, "irq_set", 3, 0, fl(1'b1));
        negs(10);

        c = cyc;
        flag_clear[0] = 1'b1;
        push(c + 1, "clr_rise", 1, 0, 1'b0);
        push(c + 1, "irq_hold", 3, 0, fl(1'b1));
        push(c + 2, "irq_clr", 3, 0, 1'b0);
        negs(1);
        flag_clear[0] = 1'b0;
        negs(3);

        c = cyc;
        data_from_gpio[0] = 1'b0;
        push(c + 6, "fall_early", 0, 0, 1'b1);
        push(c + 7, "fall_exact", 0, 0, 1'b0);
        push(c + 7, "fall_set", 2, 0, fl(1'b1));
        negs(10);

        c = cyc;
        flag_clear[0] = 1'b1;
        push(c + 1, "clr_fall", 2, 0, 1'b0);
        negs(1);
        flag_clear[0] = 1'b0;
        negs(3);

        c = cyc;
        push(c + 7, "pulse5", 0, 0, 1'b0);
        push(c + 10, "pulse5_hold", 0, 0, 1'b0);
        push(c + 10, "pulse5_flag", 1, 0, 1'b0);
        data_from_gpio[0] = 1'b1;
        negs(5);
        data_from_gpio[0] = 1'b0;
        negs(10);

        c = cyc;
        push(c + 6, "pulse6_early", 0, 0, 1'b0);
        push(c + 7, "pulse6_rise", 0, 0, 1'b1);
        push(c + 7, "pulse6_flag", 1, 0, fl(1'b1));
        push(c + 13, "pulse6_fall", 0, 0, 1'b0);
        data_from_gpio[0] = 1'b1;
        negs(6);
        data_from_gpio[0] = 1'b0;
        negs(16);

        flag_clear[0] = 1'b1;
        negs(1);
        flag_clear[0] = 1'b0;
        negs(2);

        c = cyc;
        push(c + 6, "sc_pre", 1, 0, 1'b0);
        push(c + 7, "sc_rise", 0, 0, 1'b1);
        push(c + 7, "sc_setwins", 1, 0, fl(1'b1));
        push(c + 7, "sc_irq_lag", 3, 0, 1'b0);
        push(c + 8, "sc_keep", 1, 0, fl(1'b1));
        push(c + 8, "sc_irq", 3, 0, fl(1'b1));
        data_from_gpio[0] = 1'b1;
        negs(6);
        flag_clear[0] = 1'b1;
        negs(1);
        flag_clear[0] = 1'b0;
        negs(3);

        c = cyc;
        flag_clear[0] = 1'b1;
        push(c + 1, "lone_clr", 1, 0, 1'b0);
        push(c + 1, "lone_irq_hold", 3, 0, fl(1'b1));
        push(c + 2, "lone_irq_clr", 3, 0, 1'b0);
        negs(1);
        flag_clear[0] = 1'b0;
        negs(3);

        c = cyc;
        for (int i = 0; i < 8; i++) push(c + i + 2, "byp3", 0, 3, (i % 2 == 0) ? 1'b1 : 1'b0);
        push(c + 2, "byp_rise3", 1, 3, fl(1'b1));
        push(c + 3, "byp_fall3", 2, 3, fl(1'b1));
        push(c + 6, "mask_irq", 3, 0, 1'b0);
        push(c + 6, "indep0", 0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            data_from_gpio[3] = (i % 2 == 0) ? 1'b1 : 1'b0;
            negs(1);
        end
        data_from_gpio[3] = 1'b0;
        negs(4);

        c = cyc;
        data_from_gpio[0] = 1'b0;
        push(c + 4, "pdec_hold", 0, 0, 1'b1);
        push(c + 5, "pdec_upd", 0, 0, 1'b0);
        negs(4);
        filt_period = 8'd1;
        negs(1);
        filt_period = 8'd5;
        negs(3);

        c = cyc;
        data_from_gpio[0] = 1'b1;
        push(c + 3, "ena_pre", 0, 0, 1'b0);
        push(c + 4, "ena_off", 0, 0, 1'b1);
        push(c + 11, "ena_restart", 0, 0, 1'b1);
        push(c + 12, "ena_fall", 0, 0, 1'b0);
        negs(3);
        filt_ena[0] = 1'b0;
        negs(2);
        filt_ena[0] = 1'b1;
        data_from_gpio[0] = 1'b0;
        negs(15);

        filt_period = 8'd200;
        filt_ena[1] = 1'b0;
        data_from_gpio[1] = 1'b1;
        negs(3);
        data_from_gpio[0] = 1'b1;
        negs(50);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_filt", data_filtered, '0);
        chk("arst_rise", rise_flags, '0);
        chk("arst_fall", fall_flags, '0);
        chk("arst_irq", W'(irq), '0);
        @(negedge clk);
        reset_n = 1'b1;
        c = cyc;
        push(c + 1, "rel_byp_early", 0, 1, 1'b0);
        push(c + 2, "rel_byp", 0, 1, 1'b1);
        push(c + 201, "rel_early", 0, 0, 1'b0);
        push(c + 202, "rel_lat", 0, 0, 1'b1);
        push(c + 202, "rel_rise", 1, 0, fl(1'b1));
        push(c + 203, "rel_irq", 3, 0, fl(1'b1));
        negs(210);

        chk("sb_drain", W'(sb.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gpio_in_filter.md
GPIO_IN_FILTER -- requirements
Module: gpio_in_filter

Interface
REQ-001 SHALL have parameter IOWidth, default 36, meaning the number of GPIO bits, matching the bidir_io stage that feeds this block.
REQ-002 SHALL have parameter FiltWidth, default 8, meaning the width of the filter period and of each per-bit counter.
REQ-003 SHALL have clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have data_from_gpio, input, IOWidth, raw pin samples from the bidir_io stage.
REQ-006 SHALL have filt_ena, input, IOWidth, per-bit filter enable (0 = bypass).
REQ-007 SHALL have filt_period, input, FiltWidth, a global stable-count threshold P.
REQ-008 SHALL have data_filtered, output, IOWidth, the debounced pin state.
REQ-009 SHALL have rise_flags, output, IOWidth, sticky rising-edge flags.
REQ-010 SHALL have fall_flags, output, IOWidth, sticky falling-edge flags.
REQ-011 SHALL have flag_clear, input, IOWidth, a one-cycle pulse per bit that clears both flags of that bit.
REQ-012 SHALL have rise_mask, input, IOWidth, the rising-flag interrupt enable.
REQ-013 SHALL have fall_mask, input, IOWidth, the falling-flag interrupt enable.
REQ-014 SHALL have irq, output, 1, a level interrupt request.

Function
REQ-015 SHALL resample each data_from_gpio bit into a sync register every cycle.
REQ-016 SHALL hold, per bit, a FiltWidth counter that resets to 0 on every edge where sync equals data_filtered.
REQ-017 With filt_ena=1, on each edge where sync differs from data_filtered:
- counter >= P: data_filtered takes sync and counter clears;
- otherwise: counter increments.
REQ-018 Latency: a data_from_gpio change held stable SHALL appear on data_filtered exactly P+2 clock edges later.
- P=0 gives 2 edges.
REQ-019 A sync-level pulse shorter than P+1 cycles SHALL NOT change data_filtered.
REQ-020 The counter compare SHALL be ">=", so a filt_period decrease mid-count updates on the next edge; the counter SHALL saturate and never wrap.
REQ-021 With filt_ena=0, data_filtered SHALL take sync every edge (2-edge latency) and the counter SHALL hold 0.
REQ-022 Toggling filt_ena mid-count SHALL neither glitch data_filtered nor use a stale count.
- The counter restarts from 0 when filtering is re-enabled.
REQ-023 A data_filtered 0->1 update SHALL set rise_flags on the same edge; a 1->0 update SHALL set fall_flags.
REQ-024 flag_clear SHALL clear both flags of its bit on the next edge.
REQ-025 If a set and a clear coincide on one bit, set SHALL win.
REQ-026 irq SHALL be registered as OR-reduce((rise_flags & rise_mask) | (fall_flags & fall_mask)), asserting one edge after the qualifying flag.
REQ-027 Bits SHALL be fully independent; no bit's state affects another bit.

Reset
REQ-028 reset_n low SHALL asynchronously force sync, data_filtered, all counters, rise_flags, fall_flags and irq to 0.
REQ-029 Deassertion SHALL take effect at the next clk edge.
REQ-030 A pin high through reset SHALL produce a normal rising update and rise flag after the filter latency; no suppression.
REQ-031 Reset asserted mid-count SHALL discard the count.

Configuration
REQ-032 Macro GPIO_EDGE_IRQ_EN defined: edge flags, mask logic and irq SHALL be as specified above.
REQ-033 Macro GPIO_EDGE_IRQ_EN undefined:
- rise_flags, fall_flags and irq SHALL be constant 0;
- flag_clear, rise_mask and fall_mask SHALL be ignored;
- no flag registers SHALL be synthesized;
- filtering SHALL be unchanged.

Verification
REQ-034 P=5, filt_ena bit0=1, data_from_gpio bit0 0->1 held -> data_filtered[0]=1 exactly 7 edges later; rise_flags[0]=1 on that same edge.
REQ-035 P=5, bit0 high pulse lasting 5 cycles -> data_filtered[0] stays 0 and no flags set; a 6-cycle pulse -> data_filtered[0] rises.
REQ-036 filt_ena=0, bit3 toggles every cycle -> data_filtered[3] follows with a 2-edge delay; rise and fall flags are set.
REQ-037 flag_clear[0] pulsed on the same edge as a new rise on bit0 -> rise_flags[0] remains 1.
- A later lone clear -> 0 on the next edge.
- With rise_mask[0]=1, irq tracks this one edge after the flag.
REQ-038 reset_n pulled low asynchronously mid-count with P=200 -> all outputs 0 immediately.
- After release, a held-high pin gives data_filtered=1 202 edges later.
- With GPIO_EDGE_IRQ_EN undefined, the same stimuli give flags/irq=0 and identical data_filtered.
